// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
//
// Shares one 3-bit Gray-code step counter among NREQ requesters. A
// round-robin arbiter grants one requester at a time. The granted requester's
// step count is then applied to the counter, one step per cycle. Completion is
// signalled with a one-cycle pulse. A sticky flag records any wrap of the
// counter from 7 to 0.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_n_i    synchronous active-low reset
//   req_i        per-requester request, bit i is requester i
//   req_steps_i  step count of requester i in bits [i*STEPW +: STEPW]
//   hold_i       freezes stepping while a run is in progress
//   clr_ovf_i    clears the overflow flag (a simultaneous wrap wins)
//   grant_o      one-hot grant of the current owner, zero when idle
//   busy_o       high while a grant is active
//   gray_o       counter value in Gray code
//   done_o       one-cycle pulse when the owner's steps are complete
//   done_id_o    index of the completed requester, valid with done_o
//   overflow_o   sticky wrap flag

module gray_step_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int STEPW = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*STEPW-1:0]   req_steps_i,
  input  logic                    hold_i,
  input  logic                    clr_ovf_i,
  output logic [NREQ-1:0]         grant_o,
  output logic                    busy_o,
  output logic [2:0]              gray_o,
  output logic                    done_o,
  output logic [IDW-1:0]          done_id_o,
  output logic                    overflow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bin_q, bin_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   lastGrant_q, lastGrant_d;
  logic             overflow_q, overflow_d;

  logic             winFound;
  logic [IDW-1:0]   winIdx;
  logic [STEPW-1:0] winSteps;
  logic [IDW:0]     cand;
  logic             wrapStep;

  // Round-robin search: walk the requesters starting one past the last owner,
  // wrapping modulo NREQ, and take the first one that is asking.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winSteps = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, lastGrant_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!winFound && req_i[cand[IDW-1:0]]) begin
        winFound = 1'b1;
        winIdx   = cand[IDW-1:0];
        winSteps = req_steps_i[cand[IDW-1:0]*STEPW +: STEPW];
      end
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a granted run
  // always completes. A zero-step request skips RUN and goes straight to DONE.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    rem_d       = rem_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    overflow_d  = overflow_q;
    wrapStep    = 1'b0;

    case (state_q)
      IDLE: begin
        if (winFound) begin
          owner_d = winIdx;
          rem_d   = winSteps;
          state_d = (winSteps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!hold_i) begin
          bin_d    = bin_q + 3'd1;
          rem_d    = rem_q - STEPW'(1);
          wrapStep = (bin_q == 3'd7);
          if (rem_q == STEPW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        lastGrant_d = owner_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A wrap on the same cycle as a clear keeps the flag set.
    if (wrapStep) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  // State registers. A reset in the middle of a run drops it without a Done.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      rem_q       <= '0;
      owner_q     <= '0;
      lastGrant_q <= IDW'(NREQ-1);
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      rem_q       <= rem_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      overflow_q  <= overflow_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy_o     = (state_q != IDLE);
    grant_o    = busy_o ? (NREQ'(1) << owner_q) : '0;
    done_o     = (state_q == DONE);
    done_id_o  = done_o ? owner_q : '0;
    gray_o     = bin_q ^ (bin_q >> 1);
    overflow_o = overflow_q;
  end

endmodule

// File: doc/gray_step_arbiter.md
Name: gray_step_arbiter

Overview:
- Shares one 3-bit Gray-code step counter among NREQ requesters.
- Each requester asks to advance the shared counter by a number of steps. A round-robin arbiter grants one requester at a time and sequences the steps at one per cycle.
- The block signals completion, and keeps a sticky wrap/overflow flag.
- It sits between the client blocks and the Gray position output used downstream.

Parameters:
- NREQ, 4: number of requesters; legal 2..8.
- IDW, 2: requester index width, equal to clog2(NREQ).
- STEPW, 3: width of each step-count field.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Req  in  NREQ  per-requester request; bit i is requester i.
- Req_steps  in  NREQ*STEPW  step count of requester i in bits [i*STEPW +: STEPW].
- Hold  in  1  when 1, freezes stepping in RUN.
- Clr_ovf  in  1  clears Overflow.
- Grant  out  NREQ  one-hot grant for the current owner; 0 when idle.
- Busy  out  1  1 while a grant is active.
- Gray  out  3  current counter value in Gray code: bin ^ (bin >> 1).
- Done  out  1  one-cycle pulse when the owner's steps are complete.
- Done_id  out  IDW  index of the completed requester; valid while Done=1.
- Overflow  out  1  sticky flag, set on a bin wrap from 7 to 0.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - state=IDLE; bin=0; Gray=0; Grant=0; Busy=0; Done=0; Done_id=0; Overflow=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - Reset mid-RUN aborts the transfer silently: no Done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If Req is nonzero, pick the winner round-robin: the first set bit searching from last_grant+1 upward, with modulo-NREQ wrap.
  - Latch that requester's step field into rem.
  - Set Grant to the winner's one-hot and Busy=1.
  - Next state is RUN if the steps are nonzero, otherwise DONE.
  - Grant and Busy become visible the cycle after Req is sampled.
- RUN:
  - If Hold=0: bin <= bin+1 (3-bit wrap) and rem <= rem-1.
  - If rem==1 and Hold=0, go to DONE.
  - If Hold=1: bin and rem unchanged, stay in RUN.
  - Grant and Busy stay at 1.
- DONE (exactly one cycle):
  - Done=1, Done_id=owner index; Grant and Busy still asserted.
  - last_grant <= owner; next state IDLE.
  - Grant, Busy and Done go to 0 on entry to IDLE.
- Latency: Req sampled in cycle t gives Grant at t+1 and the first Gray change at t+2. With S steps and no Hold, the final Gray value and Done both appear at t+1+S. The next grant is possible at t+3+S at the earliest.
- Steps=0: IDLE goes straight to DONE; Done appears at t+1 and bin is unchanged.
- Req and Req_steps are sampled only in IDLE.
  - Changes or deassertion during RUN/DONE are ignored; the granted run always completes.
  - A requester still asserting Req after its Done is re-arbitrated normally and gets lowest priority.
- Overflow:
  - Set to 1 on any RUN step where bin goes from 7 to 0.
  - Cleared when Clr_ovf=1.
  - If a set and Clr_ovf occur in the same cycle, the set wins and Overflow stays 1.
  - bin is never reset by arbitration; it is only changed by steps and Reset_n.
- Grant is always one-hot or zero. Done is never asserted in consecutive cycles.

Test Plan:
1. Reset, then Req=0001 with steps0=3 → Grant=0001 one cycle later. Gray sequence 0,1,3,2 with one change per cycle. Done=1 with Done_id=0 in the same cycle Gray=2. Overflow=0.
2. After reset, Req=1111 held, all steps=1 → grants in order 0001, 0010, 0100, 1000, then 0001 again. Each Done is followed by a 1-cycle IDLE gap.
3. Steps 7 for requester 2, then steps 2 for requester 3 → bin reaches 7, then 0, 1. Overflow rises on the 7→0 step and stays 1. Clr_ovf=1 alone clears it. Clr_ovf asserted on the same cycle as a wrap leaves Overflow=1.
4. Steps=4 with Hold=1 for 3 cycles mid-RUN → Gray frozen for those 3 cycles. Done is delayed by exactly 3 cycles. Final Gray equals the no-Hold result.
5. Steps=0 on requester 1 → Grant=0010 and Done=1 with Done_id=1 in the same cycle, one cycle after the request. Gray is unchanged.
6. Reset_n=0 during RUN at bin=5 → on the next cycle Gray=0, Grant=0, Busy=0, Overflow=0, and no Done pulse. A subsequent Req from 1 and 3 together grants requester 1 first.
